// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register addresses, field positions and exception codes.
// The optional Count/Compare timer is enabled by defining CP0_TIMER_EN.
package cp0_pkg;

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_SR       = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;

  localparam int IM_LSB      = 10;
  localparam int IP_LSB      = 10;
  localparam int INT_FIELD_W = 6;
  localparam int EXL_BIT     = 1;
  localparam int IE_BIT      = 0;
  localparam int BD_BIT      = 31;
  localparam int EXCCODE_LSB = 2;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Address-error exceptions are the only ones that capture BadVAddr.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// Per-line flop synchroniser for the external interrupt inputs.
// STAGES = 0 passes the lines straight through.
module cp0_int_sync #(
  parameter int NUM    = 6,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NUM-1:0] async_in,
  output logic [NUM-1:0] sync_out
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign sync_out = async_in;
    end else begin : g_chain
      logic [STAGES-1:0][NUM-1:0] chain;

      always_ff @(posedge clk) begin
        if (reset) begin
          chain <= '0;
        end else begin
          chain[0] <= async_in;
          for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
          end
        end
      end

      assign sync_out = chain[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: SR, Cause, EPC, PrID, BadVAddr, interrupt/exception arbitration.
// Define CP0_TIMER_EN to add the Count/Compare timer on IP bit 15.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter int          NUM_HWINT   = 6,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] PRID_VAL    = 32'h16061131
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rd_addr,
  output logic [31:0]          rd_data,
  input  logic [4:0]           wr_addr,
  input  logic [31:0]          wr_data,
  input  logic                 wr_en,
  input  logic [31:0]          pc,
  input  logic                 in_delay_slot,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          bad_vaddr,
  input  logic                 eret,
  input  logic [NUM_HWINT-1:0] hw_int,
  output logic                 int_req,
  output logic                 exc_req,
  output logic [31:0]          epc
);

  localparam logic [5:0] HW_MASK = 6'h3f >> (6 - NUM_HWINT);
`ifdef CP0_TIMER_EN
  localparam logic [5:0] TIMER_IP = 6'b100000;
`else
  localparam logic [5:0] TIMER_IP = 6'b000000;
`endif
  // IM bits that exist; the rest are forced to 0 on write so they read 0.
  localparam logic [5:0] IM_MASK = HW_MASK | TIMER_IP;

  logic [NUM_HWINT-1:0] hw_sync;
  logic [5:0]           im_q;
  logic [5:0]           ip_q;
  logic [5:0]           ip_now;
  logic                 exl_q;
  logic                 ie_q;
  logic                 bd_q;
  logic [4:0]           exc_code_q;
  logic [31:0]          epc_q;
  logic [31:0]          bad_vaddr_q;
  logic [31:0]          epc_next;
  logic                 wr_ok;
  logic                 timer_pend;

  cp0_int_sync #(
    .NUM    (NUM_HWINT),
    .STAGES (SYNC_STAGES)
  ) u_int_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (hw_int),
    .sync_out (hw_sync)
  );

  always_comb begin
    ip_now = '0;
    ip_now[NUM_HWINT-1:0] = hw_sync;
    ip_now = ip_now | (TIMER_IP & {6{timer_pend}});
  end

  assign int_req  = (|(ip_now & im_q)) & ie_q & ~exl_q;
  assign exc_req  = (exc_code != EXC_INT) & ~exl_q;
  // A taken interrupt or exception squashes the committing mtc0.
  assign wr_ok    = wr_en & ~int_req & ~exc_req;
  assign epc_next = in_delay_slot ? (pc - 32'd4) : pc;
  assign epc      = epc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q        <= '0;
      ip_q        <= '0;
      exl_q       <= 1'b0;
      ie_q        <= 1'b0;
      bd_q        <= 1'b0;
      exc_code_q  <= '0;
      epc_q       <= '0;
      bad_vaddr_q <= '0;
    end else begin
      ip_q <= ip_now;
      if (int_req || exc_req) begin
        epc_q <= epc_next;
        bd_q  <= in_delay_slot;
        exl_q <= 1'b1;
        if (int_req) begin
          exc_code_q <= EXC_INT;
        end else begin
          exc_code_q <= exc_code;
          if (is_addr_exc(exc_code)) bad_vaddr_q <= bad_vaddr;
        end
      end else begin
        if (wr_ok && wr_addr == ADDR_SR) begin
          im_q  <= wr_data[IM_LSB +: INT_FIELD_W] & IM_MASK;
          ie_q  <= wr_data[IE_BIT];
          exl_q <= wr_data[EXL_BIT] & ~eret;
        end else if (eret) begin
          exl_q <= 1'b0;
        end
        if (wr_ok && wr_addr == ADDR_EPC) epc_q <= wr_data;
      end
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] count_next;
  logic        timer_pend_q;

  assign count_next = (wr_ok && wr_addr == ADDR_COUNT) ? wr_data : count_q + 32'd1;

  // A Compare write clears the pending flag even if Count matches in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      compare_q    <= '0;
      timer_pend_q <= 1'b0;
    end else begin
      count_q <= count_next;
      if (wr_ok && wr_addr == ADDR_COMPARE) begin
        compare_q    <= wr_data;
        timer_pend_q <= 1'b0;
      end else if (count_next == compare_q) begin
        timer_pend_q <= 1'b1;
      end
    end
  end

  assign timer_pend = timer_pend_q;
`else
  assign timer_pend = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_SR: begin
        rd_data[IM_LSB +: INT_FIELD_W] = im_q;
        rd_data[EXL_BIT]               = exl_q;
        rd_data[IE_BIT]                = ie_q;
      end
      ADDR_CAUSE: begin
        rd_data[BD_BIT]                = bd_q;
        rd_data[IP_LSB +: INT_FIELD_W] = ip_q;
        rd_data[EXCCODE_LSB +: 5]      = exc_code_q;
      end
      ADDR_EPC:      rd_data = epc_q;
      ADDR_PRID:     rd_data = PRID_VAL;
      ADDR_BADVADDR: rd_data = bad_vaddr_q;
`ifdef CP0_TIMER_EN
      ADDR_COUNT:    rd_data = count_q;
      ADDR_COMPARE:  rd_data = compare_q;
`endif
      default:       rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: register table, directed corner sequences, random vs model.
// Timer sequences are included when CP0_TIMER_EN is defined.
module tb_cp0_regfile;
  import cp0_pkg::*;

  localparam int          W      = 66;
  localparam int          NSYNC  = 2;
  localparam logic [31:0] PRID   = 32'h16061131;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr, wr_addr, exc_code;
  logic [31:0] rd_data, wr_data, pc, bad_vaddr, epc;
  logic        wr_en, in_delay_slot, eret, int_req, exc_req;
  logic [5:0]  hw_int;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: whole architectural words plus a queue standing in for the synchroniser delay
  logic [31:0] m_sr, m_cause, m_epc, m_badv, m_count, m_compare;
  bit          m_pend;
  logic [5:0]  m_sync_q[$];

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [31:0] exp;
  } vec_t;
  vec_t       vt[9];
  logic [4:0] addr_tab[9];
  bit         found;

  always #5 clk = ~clk;

  cp0_regfile #(
    .NUM_HWINT   (6),
    .SYNC_STAGES (NSYNC),
    .PRID_VAL    (PRID)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .pc            (pc),
    .in_delay_slot (in_delay_slot),
    .exc_code      (exc_code),
    .bad_vaddr     (bad_vaddr),
    .eret          (eret),
    .hw_int        (hw_int),
    .int_req       (int_req),
    .exc_req       (exc_req),
    .epc           (epc)
  );

  function automatic logic [5:0] m_ip_now();
    logic [5:0] ip;
    ip = m_sync_q[0];
`ifdef CP0_TIMER_EN
    if (m_pend) ip = ip | 6'b100000;
`endif
    return ip;
  endfunction

  function automatic bit m_int();
    return ((m_ip_now() & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic bit m_exc();
    return (exc_code != 5'd0) && !m_sr[1];
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      5'd8:    return m_badv;
`ifdef CP0_TIMER_EN
      5'd9:    return m_count;
      5'd11:   return m_compare;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_sr = 0; m_cause = 0; m_epc = 0; m_badv = 0;
    m_count = 0; m_compare = 0; m_pend = 0;
    m_sync_q.delete();
    for (int i = 0; i < NSYNC; i++) m_sync_q.push_back(6'd0);
  endtask

  // One clock edge of the architectural rules, applied to the current inputs.
  task automatic m_edge();
    logic [5:0]  ip;
    bit          intr, exc, wr;
    logic [31:0] new_count;
    if (reset) begin
      m_reset();
      return;
    end
    ip   = m_ip_now();
    intr = m_int();
    exc  = m_exc();
    wr   = wr_en && !intr && !exc;
`ifdef CP0_TIMER_EN
    new_count = (wr && wr_addr == 5'd9) ? wr_data : m_count + 1;
    if (wr && wr_addr == 5'd11) begin
      m_compare = wr_data;
      m_pend    = 0;
    end else if (new_count == m_compare) begin
      m_pend = 1;
    end
    m_count = new_count;
`else
    new_count = 0;
`endif
    m_cause[15:10] = ip;
    if (intr || exc) begin
      m_epc       = in_delay_slot ? pc - 32'd4 : pc;
      m_cause[31] = in_delay_slot;
      m_cause[6:2] = intr ? 5'd0 : exc_code;
      m_sr[1]     = 1'b1;
      if (!intr && (exc_code == 5'd4 || exc_code == 5'd5)) m_badv = bad_vaddr;
    end else begin
      if (wr && wr_addr == 5'd12) m_sr = wr_data & 32'h0000_FC03;
      if (eret) m_sr[1] = 1'b0;
      if (wr && wr_addr == 5'd14) m_epc = wr_data;
    end
    void'(m_sync_q.pop_front());
    m_sync_q.push_back(hw_int);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    check(name, rd_data, exp);
  endtask

  task automatic clr();
    reset = 0; wr_en = 0; eret = 0; exc_code = 0; in_delay_slot = 0;
  endtask

  // Called at a falling edge with inputs set; checks outputs, then advances one cycle.
  task automatic tick(input bit do_chk);
    logic [W-1:0] e;
    #1;
    if (do_chk) begin
      exp_q.push_back({m_int(), m_exc(), m_epc, m_read(rd_addr)});
      e = exp_q.pop_front();
      check("int_req", 32'(int_req), 32'(e[65]));
      check("exc_req", 32'(exc_req), 32'(e[64]));
      check("epc", epc, e[63:32]);
      check("rd_data", rd_data, e[31:0]);
    end
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; wr_en = 0; eret = 0; exc_code = 0; in_delay_slot = 0;
    rd_addr = 0; wr_addr = 0; wr_data = 0; pc = 0; bad_vaddr = 0; hw_int = 0;
    addr_tab = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd3};
    m_reset();
    @(negedge clk);
    repeat (3) tick(0);
    clr();

    rd_chk("reset_sr", 12, 32'd0);
    rd_chk("reset_prid", 15, PRID);
    check("reset_epc", epc, 32'd0);
    check("reset_int_req", 32'(int_req), 32'd0);
    check("reset_exc_req", 32'(exc_req), 32'd0);
    tick(1);

    // Register access table: write, then read back on the following cycle
    vt[0] = '{5'd14, 32'h1234_5678, 5'd14, 32'h1234_5678};
    vt[1] = '{5'd12, 32'hFFFF_FFFC, 5'd12, 32'h0000_FC00};
    vt[2] = '{5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000};
    vt[3] = '{5'd15, 32'h0000_0000, 5'd15, PRID};
    vt[4] = '{5'd8,  32'hFFFF_FFFF, 5'd8,  32'h0000_0000};
    vt[5] = '{5'd3,  32'hFFFF_FFFF, 5'd3,  32'h0000_0000};
`ifdef CP0_TIMER_EN
    vt[6] = '{5'd11, 32'hFFFF_0000, 5'd11, 32'hFFFF_0000};
`else
    vt[6] = '{5'd11, 32'hFFFF_0000, 5'd11, 32'h0000_0000};
`endif
    vt[7] = '{5'd12, 32'h0000_0003, 5'd12, 32'h0000_0003};
    vt[8] = '{5'd12, 32'h0000_0000, 5'd12, 32'h0000_0000};
    for (int i = 0; i < 9; i++) begin
      clr();
      wr(vt[i].wa, vt[i].wd);
      rd_addr = vt[i].ra;
      tick(1);
      clr();
      rd_chk($sformatf("table_%0d", i), vt[i].ra, vt[i].exp);
    end

    // Interrupt latency through the synchroniser
    clr(); wr(12, 32'h0000_0401); tick(1);
    clr(); pc = 32'h2000; hw_int = 6'b000001; tick(1);
    #1 check("int_lat1", 32'(int_req), 32'd0);
    tick(1);
    #1 check("int_lat2", 32'(int_req), 32'd1);
    tick(1);
    check("int_epc", epc, 32'h2000);
    rd_chk("int_cause", 13, 32'h0000_0400);
    rd_chk("int_sr", 12, 32'h0000_0403);
    check("int_drop", 32'(int_req), 32'd0);
    clr(); hw_int = 0; eret = 1; wr(12, 32'h0000_0800); tick(1);
    clr(); rd_chk("eret_mtc0_sr", 12, 32'h0000_0800);
    tick(1); tick(1);

    // Address exception in a delay slot
    clr(); exc_code = EXC_ADEL; bad_vaddr = 32'h1003; in_delay_slot = 1; pc = 32'h3008;
    #1 check("exc_req", 32'(exc_req), 32'd1);
    tick(1);
    clr();
    check("exc_epc", epc, 32'h3004);
    rd_chk("exc_cause", 13, 32'h8000_0010);
    rd_chk("exc_badv", 8, 32'h1003);
    rd_chk("exc_sr", 12, 32'h0000_0802);

    // Masked by EXL, then ERET
    clr(); exc_code = EXC_OV; pc = 32'h5000;
    #1 check("exl_mask", 32'(exc_req), 32'd0);
    tick(1);
    clr();
    check("exl_epc_hold", epc, 32'h3004);
    rd_chk("exl_cause_hold", 13, 32'h8000_0010);
    eret = 1; tick(1);
    clr(); rd_chk("eret_sr", 12, 32'h0000_0800);

    // Interrupt, exception and mtc0 in the same cycle
    wr(12, 32'h0000_0401); tick(1);
    clr(); hw_int = 6'b000001; pc = 32'h4000; tick(1); tick(1);
    exc_code = EXC_RI; wr(14, 32'h0000_DEAD);
    #1 check("both_int", 32'(int_req), 32'd1);
    check("both_exc", 32'(exc_req), 32'd1);
    tick(1);
    clr();
    check("both_epc", epc, 32'h4000);
    rd_chk("both_cause", 13, 32'h0000_0400);
    rd_chk("both_sr", 12, 32'h0000_0403);
    hw_int = 0; eret = 1; wr(12, 32'h0); tick(1);
    clr(); tick(1); tick(1);

    // pc-4 wraps
    clr(); exc_code = EXC_ADES; in_delay_slot = 1; pc = 32'h0; bad_vaddr = 32'hABCD_0000;
    tick(1);
    clr();
    check("wrap_epc", epc, 32'hFFFF_FFFC);
    rd_chk("wrap_badv", 8, 32'hABCD_0000);
    rd_chk("wrap_cause", 13, 32'h8000_0014);

`ifdef CP0_TIMER_EN
    clr(); eret = 1; tick(1);
    clr(); wr(11, 32'd20); tick(1);
    clr(); wr(9, 32'd15); tick(1);
    clr(); wr(12, 32'h0000_8001); tick(1);
    clr();
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      #1;
      if (int_req) found = 1;
      else tick(1);
    end
    check("timer_int", 32'(found), 32'd1);
    rd_chk("timer_count", 9, 32'd20);
    tick(1);
    rd_chk("timer_ip_set", 13, 32'h0000_8000);
`endif

    // Reset while EXL=1
    clr(); reset = 1; tick(1);
    clr();
    rd_chk("rst_sr", 12, 32'd0);
    rd_chk("rst_cause", 13, 32'd0);
`ifdef CP0_TIMER_EN
    rd_chk("rst_count", 9, 32'd0);
`endif
    check("rst_epc", epc, 32'd0);
    check("rst_int_req", 32'(int_req), 32'd0);
    check("rst_exc_req", 32'(exc_req), 32'd0);
    tick(1);
    rd_chk("rst_prid", 15, PRID);
    rd_chk("rst_badv", 8, 32'd0);

`ifdef CP0_TIMER_EN
    clr(); wr(11, 32'd5); tick(1);
    clr(); repeat (5) tick(1);
    rd_chk("pend_ip_set", 13, 32'h0000_8000);
    wr(11, 32'h100); tick(1);
    clr(); tick(1);
    rd_chk("pend_ip_clear", 13, 32'd0);
`endif

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      clr();
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom);
      exc_code      = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'd0;
      bad_vaddr     = $urandom;
      pc            = $urandom & 32'hFFFF_FFFC;
      in_delay_slot = 1'($urandom_range(0, 1));
      eret          = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) begin
        wr(addr_tab[$urandom_range(0, 8)], $urandom);
        if (wr_addr == 5'd12 && $urandom_range(0, 1) == 1) wr_data[1] = 1'b0;
      end
      rd_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : addr_tab[$urandom_range(0, 8)];
      tick(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
